// File: rtl/reg_file_scoreboard.sv
// Purpose     : register file (2 comb read ports, 1 write port, hardwired zero reg) with
//               optional write->read bypass and per-register pending scoreboard.
// Latency     : reads 0 cycles (bypassed write visible same cycle when BYPASS=1, else next cycle);
//               pending marks and pend_cnt update on the rising edge.
// Backpressure: none; every write/issue is accepted, hazards are reported through busy_a/busy_b.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset (clears everything)
//   wr_en, wr_addr, wr_data         writeback port
//   rd_addr_a/b -> rd_data_a/b      combinational read ports
//   busy_a/b                        read register has an outstanding producer
//   issue_en, issue_addr            mark a register pending at issue
//   pend_cnt                        registered count of pending registers
module reg_file_scoreboard #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int ZERO_IDX = 31,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_addr,
    output logic             busy_a,
    output logic             busy_b,
    output logic [AW:0]      pend_cnt
);

    // Scoreboard spans the full address space so any address can index it;
    // entries at or above DEPTH are held at zero.
    localparam int            NP      = 1 << AW;
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] ZERO_W  = AW'(ZERO_IDX);
    localparam logic          BYP     = (BYPASS != 0);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [NP-1:0]    pending;
    logic [NP-1:0]    pend_nxt;
    logic [AW:0]      cnt_nxt;
    logic             wr_ok;

    // Address names a real, writable register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W) && (a != ZERO_W);
    endfunction

    // A write this cycle that the read port at address a would forward.
    function automatic logic byp_hit(input logic [AW-1:0] a);
        return BYP && wr_en && (wr_addr == a);
    endfunction

    function automatic logic [WIDTH-1:0] rd_val(input logic [AW-1:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        if (!reset && addr_ok(a)) begin
            v = byp_hit(a) ? wr_data : regs[a];
        end
        return v;
    endfunction

    function automatic logic rd_busy(input logic [AW-1:0] a);
        logic b;
        b = 1'b0;
        if (!reset && addr_ok(a)) begin
            b = pending[a] && !byp_hit(a);
        end
        return b;
    endfunction

    assign wr_ok = wr_en && addr_ok(wr_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Next pending vector: a new producer (issue) wins over a retiring one (write).
    always_comb begin
        pend_nxt = '0;
        cnt_nxt  = '0;
        for (int r = 0; r < NP; r++) begin
            if (r >= DEPTH || r == ZERO_IDX) begin
                pend_nxt[r] = 1'b0;
            end else if (issue_en && issue_addr == AW'(r)) begin
                pend_nxt[r] = 1'b1;
            end else if (wr_en && wr_addr == AW'(r)) begin
                pend_nxt[r] = 1'b0;
            end else begin
                pend_nxt[r] = pending[r];
            end
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, pend_nxt[r]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    // Outputs are gated by reset so a bypassed write cannot leak through while held.
    assign rd_data_a = rd_val(rd_addr_a);
    assign rd_data_b = rd_val(rd_addr_b);
    assign busy_a    = rd_busy(rd_addr_a);
    assign busy_b    = rd_busy(rd_addr_b);

endmodule

// File: tb/tb_reg_file_scoreboard.sv
module tb_reg_file_scoreboard;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          issue_en;
    logic [AW-1:0] issue_addr;

    logic [63:0]   rda   [3];
    logic [63:0]   rdb   [3];
    logic          busya [3];
    logic          busyb [3];
    logic [AW:0]   pcnt  [3];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // 0: default (bypass), 1: no bypass, 2: DEPTH=20 / ZERO_IDX=19
    reg_file_scoreboard #(.WIDTH(64), .DEPTH(32), .ZERO_IDX(31), .BYPASS(1)) u0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda[0]), .rd_addr_b(rd_addr_b), .rd_data_b(rdb[0]),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_a(busya[0]), .busy_b(busyb[0]),
        .pend_cnt(pcnt[0]));
    reg_file_scoreboard #(.WIDTH(64), .DEPTH(32), .ZERO_IDX(31), .BYPASS(0)) u1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda[1]), .rd_addr_b(rd_addr_b), .rd_data_b(rdb[1]),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_a(busya[1]), .busy_b(busyb[1]),
        .pend_cnt(pcnt[1]));
    reg_file_scoreboard #(.WIDTH(64), .DEPTH(20), .ZERO_IDX(19), .BYPASS(1)) u2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda[2]), .rd_addr_b(rd_addr_b), .rd_data_b(rdb[2]),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_a(busya[2]), .busy_b(busyb[2]),
        .pend_cnt(pcnt[2]));

    // Reference model: architectural register contents and pending flags per configuration.
    int          cfg_depth [3] = '{32, 32, 20};
    int          cfg_zero  [3] = '{31, 31, 19};
    bit          cfg_byp   [3] = '{1'b1, 1'b0, 1'b1};
    logic [63:0] mreg  [3][32];
    bit          mpend [3][32];

    function automatic bit m_valid(int c, int a);
        return (a < cfg_depth[c]) && (a != cfg_zero[c]);
    endfunction

    function automatic logic [63:0] m_rd(int c, int a);
        if (reset || !m_valid(c, a)) return 64'd0;
        if (cfg_byp[c] && wr_en && int'(wr_addr) == a) return wr_data;
        return mreg[c][a];
    endfunction

    function automatic logic [63:0] m_busy(int c, int a);
        if (reset || !m_valid(c, a)) return 64'd0;
        if (cfg_byp[c] && wr_en && int'(wr_addr) == a) return 64'd0;
        return {63'd0, mpend[c][a]};
    endfunction

    function automatic logic [63:0] m_cnt(int c);
        int n;
        n = 0;
        for (int r = 0; r < 32; r++) n += int'(mpend[c][r]);
        return 64'(n);
    endfunction

    task automatic m_clear();
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 32; r++) begin
                mreg[c][r]  = 64'd0;
                mpend[c][r] = 1'b0;
            end
    endtask

    task automatic m_edge();
        for (int c = 0; c < 3; c++) begin
            if (wr_en && m_valid(c, int'(wr_addr))) mreg[c][wr_addr] = wr_data;
            for (int r = 0; r < 32; r++) begin
                if (!m_valid(c, r)) mpend[c][r] = 1'b0;
                else if (issue_en && int'(issue_addr) == r) mpend[c][r] = 1'b1;
                else if (wr_en && int'(wr_addr) == r) mpend[c][r] = 1'b0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(input string where);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("%s rda%0d", where, c), rda[c], m_rd(c, int'(rd_addr_a)));
            check($sformatf("%s rdb%0d", where, c), rdb[c], m_rd(c, int'(rd_addr_b)));
            check($sformatf("%s busya%0d", where, c), {63'd0, busya[c]}, m_busy(c, int'(rd_addr_a)));
            check($sformatf("%s busyb%0d", where, c), {63'd0, busyb[c]}, m_busy(c, int'(rd_addr_b)));
            check($sformatf("%s pcnt%0d", where, c), {58'd0, pcnt[c]}, m_cnt(c));
        end
    endtask

    // Inputs settle, outputs are compared before the edge, then the model takes the edge.
    task automatic step(input string where);
        if (reset) m_clear();
        #2;
        check_all(where);
        @(posedge clk);
        if (reset) m_clear();
        else m_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_clear();
        check_all("rst");
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; issue_en = 1'b0; issue_addr = '0;
        #1;
        m_clear();
        check_all("por");
        reset = 1'b0;
        #1;

        // Reset takes effect without a clock edge
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD; issue_en = 1'b1; issue_addr = 5'd9;
        step("t1");
        wr_en = 1'b0; issue_en = 1'b0; rd_addr_a = 5'd5; rd_addr_b = 5'd9;
        #1;
        check("t1 pre rda", rda[0], 64'hDEAD);
        check("t1 pre pcnt", {58'd0, pcnt[0]}, 64'd1);
        reset = 1'b1;
        #1;
        m_clear();
        check("t1 rst rda", rda[0], 64'd0);
        check("t1 rst busyb", {63'd0, busyb[0]}, 64'd0);
        check("t1 rst pcnt", {58'd0, pcnt[0]}, 64'd0);
        check_all("t1rst");
        reset = 1'b0;
        #1;

        // Write then read on both ports
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h1234_5678_9ABC_DEF0;
        step("t2");
        wr_en = 1'b0; rd_addr_a = 5'd3; rd_addr_b = 5'd3;
        #1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("t2 rda%0d", c), rda[c], 64'h1234_5678_9ABC_DEF0);
            check($sformatf("t2 rdb%0d", c), rdb[c], 64'h1234_5678_9ABC_DEF0);
        end
        step("t2b");

        // Zero register ignores writes and issues
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1; issue_en = 1'b1; issue_addr = 5'd31;
        rd_addr_a = 5'd31;
        step("t3");
        wr_en = 1'b0; issue_en = 1'b0;
        #1;
        check("t3 rda", rda[0], 64'd0);
        check("t3 busya", {63'd0, busya[0]}, 64'd0);
        check("t3 pcnt0", {58'd0, pcnt[0]}, 64'd0);
        check("t3 pcnt1", {58'd0, pcnt[1]}, 64'd0);

        // Bypass vs no bypass
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h55; rd_addr_a = 5'd7;
        #1;
        check("t4 byp", rda[0], 64'h55);
        check("t4 nobyp", rda[1], 64'h0);
        step("t4");
        wr_en = 1'b0;
        #1;
        check("t4 nobyp next", rda[1], 64'h55);

        // Scoreboard
        do_reset();
        issue_en = 1'b1; issue_addr = 5'd9; rd_addr_a = 5'd9;
        step("t5a");
        issue_en = 1'b0;
        #1;
        check("t5 busy", {63'd0, busya[0]}, 64'd1);
        check("t5 pcnt", {58'd0, pcnt[0]}, 64'd1);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hABC;
        #1;
        check("t5 wb busy byp", {63'd0, busya[0]}, 64'd0);
        check("t5 wb busy nobyp", {63'd0, busya[1]}, 64'd1);
        step("t5b");
        wr_en = 1'b0;
        #1;
        check("t5 pcnt clr0", {58'd0, pcnt[0]}, 64'd0);
        check("t5 pcnt clr1", {58'd0, pcnt[1]}, 64'd0);
        issue_en = 1'b1; wr_en = 1'b1; issue_addr = 5'd9; wr_addr = 5'd9;
        step("t5c");
        issue_en = 1'b0; wr_en = 1'b0;
        #1;
        check("t5 set wins pcnt", {58'd0, pcnt[0]}, 64'd1);
        check("t5 set wins busy", {63'd0, busya[0]}, 64'd1);

        // Reduced depth
        do_reset();
        for (int i = 1; i <= 18; i++) begin
            issue_en = 1'b1; issue_addr = 5'(i);
            step("t6");
        end
        issue_en = 1'b0; rd_addr_a = 5'd25;
        #1;
        check("t6 pcnt", {58'd0, pcnt[2]}, 64'd18);
        check("t6 oor data", rda[2], 64'd0);
        check("t6 oor busy", {63'd0, busya[2]}, 64'd0);
        reset = 1'b1;
        #1;
        m_clear();
        check("t6 rst pcnt", {58'd0, pcnt[2]}, 64'd0);
        reset = 1'b0;
        #1;

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            reset      = ($urandom_range(63) == 0);
            wr_en      = 1'($urandom_range(1));
            wr_addr    = 5'($urandom_range(31));
            wr_data    = {$urandom(), $urandom()};
            issue_en   = 1'($urandom_range(1));
            issue_addr = 5'($urandom_range(31));
            rd_addr_a  = ($urandom_range(2) == 0) ? wr_addr : 5'($urandom_range(31));
            rd_addr_b  = ($urandom_range(3) == 0) ? rd_addr_a : 5'($urandom_range(31));
            step("rnd");
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
